// File: rtl/pulse_train_gen_pkg.sv
// rtl/pulse_train_gen_pkg.sv - shared types, default widths and phase-length helper for pulse_train_gen
package pulse_train_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 8;
  localparam int NUM_W_DEF = 8;

  // A programmed phase length of 0 is treated as 1 cycle.
  function automatic logic [31:0] max1(input logic [31:0] x);
    return (x == 32'd0) ? 32'd1 : x;
  endfunction

endpackage

// File: rtl/pulse_train_gen_phase_counter.sv
// rtl/pulse_train_gen_phase_counter.sv - loadable down-counter with zero flag timing each pulse phase
module phase_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - burst pulse generator with busy/done; optional abort via PULSE_TRAIN_GEN_ABORT_EN
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  input  logic [NUM_W-1:0] num_pulses,
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  input  logic             abort,
`endif
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             ph_load;
  logic             ph_dec;
  logic [CNT_W-1:0] ph_val;
  logic             ph_expire;

  // Phase lengths are stored as (effective length - 1) so the counter expires on the last cycle.
  logic [CNT_W-1:0] high_eff_m1;
  logic [CNT_W-1:0] low_eff_m1;
  assign high_eff_m1 = CNT_W'(max1(32'(high_cycles)) - 32'd1);
  assign low_eff_m1  = CNT_W'(max1(32'(low_cycles)) - 32'd1);

  always_comb begin
    state_d = state_q;
    high_d  = high_q;
    low_d   = low_q;
    num_d   = num_q;
    pulse_d = pulse_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ph_load = 1'b0;
    ph_dec  = 1'b0;
    ph_val  = high_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_pulses != '0) begin
            high_d  = high_eff_m1;
            low_d   = low_eff_m1;
            num_d   = num_pulses;
            state_d = ST_HIGH;
            pulse_d = 1'b1;
            busy_d  = 1'b1;
            ph_load = 1'b1;
            ph_val  = high_eff_m1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (ph_expire) begin
          state_d = ST_LOW;
          pulse_d = 1'b0;
          ph_load = 1'b1;
          ph_val  = low_q;
        end else begin
          ph_dec = 1'b1;
        end
      end
      ST_LOW: begin
        if (ph_expire) begin
          num_d = num_q - NUM_W'(1);
          if (num_q == NUM_W'(1)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_HIGH;
            pulse_d = 1'b1;
            ph_load = 1'b1;
            ph_val  = high_q;
          end
        end else begin
          ph_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      pulse_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      num_d   = '0;
      ph_load = 1'b1;
      ph_val  = '0;
      ph_dec  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      high_q  <= '0;
      low_q   <= '0;
      num_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      low_q   <= low_d;
      num_q   <= num_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  phase_counter #(
    .W (CNT_W)
  ) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (ph_dec),
    .expire   (ph_expire)
  );

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - scoreboard bench for pulse_train_gen; abort cases under PULSE_TRAIN_GEN_ABORT_EN
module tb_pulse_train_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] high_cycles = 8'd0;
  logic [7:0] low_cycles = 8'd0;
  logic [7:0] num_pulses = 8'd0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       pulse_out;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  // Expected {pulse_out, busy, done} for each cycle after the launching edge.
  logic [2:0] sb_q[$];

  pulse_train_gen #(
    .CNT_W (8),
    .NUM_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .num_pulses  (num_pulses),
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    .abort       (abort),
`endif
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic push_model(input int h, input int l, input int n);
    int he, le, total;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    total = n * (he + le);
    for (int c = 1; c <= total; c++) begin
      sb_q.push_back({((c - 1) % (he + le)) < he, 1'b1, 1'b0});
    end
    sb_q.push_back(3'b001);
  endtask

  task automatic push_idle(input int cycles);
    for (int c = 0; c < cycles; c++) sb_q.push_back(3'b000);
  endtask

  task automatic launch(input int h, input int l, input int n);
    @(negedge clk);
    high_cycles = 8'(h);
    low_cycles  = 8'(l);
    num_pulses  = 8'(n);
    start       = 1'b1;
    push_model(h, l, n);
  endtask

  // kind 1: stray start at inj; kind 2: abort at inj; chain: relaunch (ch,cl,cn) in the done cycle.
  task automatic drain(input string tag, input int inj, input int kind,
                       input bit chain, input int ch, input int cl, input int cn);
    int c;
    bit chain_pending;
    logic [2:0] expv;
    c = 0;
    chain_pending = chain;
    while (sb_q.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
      abort = 1'b0;
`endif
      c++;
      expv = sb_q.pop_front();
      check($sformatf("%s_c%0d", tag, c), {pulse_out, busy, done}, expv);
      if (c == inj && kind == 1) begin
        start      = 1'b1;
        num_pulses = 8'd5;
      end
`ifdef PULSE_TRAIN_GEN_ABORT_EN
      if (c == inj && kind == 2) abort = 1'b1;
`endif
      if (chain_pending && sb_q.size() == 0) begin
        chain_pending = 1'b0;
        high_cycles = 8'(ch);
        low_cycles  = 8'(cl);
        num_pulses  = 8'(cn);
        start       = 1'b1;
        push_model(ch, cl, cn);
        c = 0;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_hold", {pulse_out, busy, done}, 3'b000);
    rst = 1'b0;
    push_idle(2);
    drain("idle_after_reset", 0, 0, 1'b0, 0, 0, 0);

    launch(2, 3, 2);
    push_idle(2);
    drain("basic", 0, 0, 1'b0, 0, 0, 0);

    launch(0, 0, 3);
    drain("zero_len", 0, 0, 1'b0, 0, 0, 0);
    launch(5, 5, 0);
    push_idle(3);
    drain("zero_num", 0, 0, 1'b0, 0, 0, 0);

    launch(4, 4, 1);
    push_idle(3);
    drain("restart_ignored", 2, 1, 1'b0, 0, 0, 0);

    launch(2, 1, 2);
    drain("b2b_first", 0, 0, 1'b1, 1, 1, 1);
    push_idle(2);
    drain("b2b_second", 0, 0, 1'b0, 0, 0, 0);

    launch(5, 2, 1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("pre_rst_c%0d", c), {pulse_out, busy, done}, sb_q.pop_front());
    end
    sb_q.delete();
    #2 rst = 1'b1;
    #1 check("rst_async_drop", {pulse_out, busy, done}, 3'b000);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_held", {pulse_out, busy, done}, 3'b000);
    end
    rst = 1'b0;
    push_idle(2);
    drain("post_rst_idle", 0, 0, 1'b0, 0, 0, 0);
    launch(1, 2, 2);
    push_idle(1);
    drain("post_rst_burst", 0, 0, 1'b0, 0, 0, 0);

`ifdef PULSE_TRAIN_GEN_ABORT_EN
    launch(3, 3, 4);
    while (sb_q.size() > 3) void'(sb_q.pop_back());
    push_idle(8);
    drain("abort", 3, 2, 1'b0, 0, 0, 0);

    @(negedge clk);
    high_cycles = 8'd2;
    low_cycles  = 8'd1;
    num_pulses  = 8'd1;
    start       = 1'b1;
    abort       = 1'b1;
    push_model(2, 1, 1);
    drain("abort_start_idle", 0, 0, 1'b0, 0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
